// File: rtl/pipe_stage_fifo.sv
// Inter-stage valid/allow_in buffer: DEPTH-entry circular store with a registered head, 1-cycle latency, sync flush.
// Backpressure: up_allow_in = !full, or with PIPE_READY=0 also raised by a same-cycle pop.
module pipe_stage_fifo #(
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 2,
  parameter bit PIPE_READY = 1'b0,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] up_data,
  output logic              up_allow_in,
  output logic              dn_valid,
  output logic [DATA_W-1:0] dn_data,
  input  logic              dn_allow_in,
  output logic [CNT_W-1:0]  count
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full, empty, push, pop;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign dn_valid = !empty;
  assign dn_data  = mem_q[rd_ptr_q];
  assign count    = count_q;

  assign pop  = dn_valid && dn_allow_in && !flush;
  // PIPE_READY=1 folds away the pop term, leaving up_allow_in purely registered.
  assign up_allow_in = PIPE_READY ? !full : (!full || pop);
  assign push = up_valid && up_allow_in && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= up_data;
    end
  end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Directed and randomised checks of pipe_stage_fifo across several DEPTH/PIPE_READY builds.
module tb_pipe_stage_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int checks   = 0;
  int failures = 0;

  // a: DEPTH=4 P0, b: DEPTH=2 P1, c/d: DEPTH=3 P0/P1, e/f: DEPTH=5 P0/P1
  logic a_flush, a_up_valid, a_up_allow_in, a_dn_valid, a_dn_allow_in;
  logic [7:0] a_up_data, a_dn_data;
  logic [2:0] a_count;
  logic b_flush, b_up_valid, b_up_allow_in, b_dn_valid, b_dn_allow_in;
  logic [7:0] b_up_data, b_dn_data;
  logic [1:0] b_count;
  logic c_flush, c_up_valid, c_up_allow_in, c_dn_valid, c_dn_allow_in;
  logic [7:0] c_up_data, c_dn_data;
  logic [1:0] c_count;
  logic d_flush, d_up_valid, d_up_allow_in, d_dn_valid, d_dn_allow_in;
  logic [7:0] d_up_data, d_dn_data;
  logic [1:0] d_count;
  logic e_flush, e_up_valid, e_up_allow_in, e_dn_valid, e_dn_allow_in;
  logic [15:0] e_up_data, e_dn_data;
  logic [2:0] e_count;
  logic f_flush, f_up_valid, f_up_allow_in, f_dn_valid, f_dn_allow_in;
  logic [15:0] f_up_data, f_dn_data;
  logic [2:0] f_count;

  pipe_stage_fifo #(.DATA_W(8), .DEPTH(4), .PIPE_READY(1'b0)) u_a (
    .clk(clk), .reset(reset), .flush(a_flush), .up_valid(a_up_valid), .up_data(a_up_data),
    .up_allow_in(a_up_allow_in), .dn_valid(a_dn_valid), .dn_data(a_dn_data),
    .dn_allow_in(a_dn_allow_in), .count(a_count));
  pipe_stage_fifo #(.DATA_W(8), .DEPTH(2), .PIPE_READY(1'b1)) u_b (
    .clk(clk), .reset(reset), .flush(b_flush), .up_valid(b_up_valid), .up_data(b_up_data),
    .up_allow_in(b_up_allow_in), .dn_valid(b_dn_valid), .dn_data(b_dn_data),
    .dn_allow_in(b_dn_allow_in), .count(b_count));
  pipe_stage_fifo #(.DATA_W(8), .DEPTH(3), .PIPE_READY(1'b0)) u_c (
    .clk(clk), .reset(reset), .flush(c_flush), .up_valid(c_up_valid), .up_data(c_up_data),
    .up_allow_in(c_up_allow_in), .dn_valid(c_dn_valid), .dn_data(c_dn_data),
    .dn_allow_in(c_dn_allow_in), .count(c_count));
  pipe_stage_fifo #(.DATA_W(8), .DEPTH(3), .PIPE_READY(1'b1)) u_d (
    .clk(clk), .reset(reset), .flush(d_flush), .up_valid(d_up_valid), .up_data(d_up_data),
    .up_allow_in(d_up_allow_in), .dn_valid(d_dn_valid), .dn_data(d_dn_data),
    .dn_allow_in(d_dn_allow_in), .count(d_count));
  pipe_stage_fifo #(.DATA_W(16), .DEPTH(5), .PIPE_READY(1'b0)) u_e (
    .clk(clk), .reset(reset), .flush(e_flush), .up_valid(e_up_valid), .up_data(e_up_data),
    .up_allow_in(e_up_allow_in), .dn_valid(e_dn_valid), .dn_data(e_dn_data),
    .dn_allow_in(e_dn_allow_in), .count(e_count));
  pipe_stage_fifo #(.DATA_W(16), .DEPTH(5), .PIPE_READY(1'b1)) u_f (
    .clk(clk), .reset(reset), .flush(f_flush), .up_valid(f_up_valid), .up_data(f_up_data),
    .up_allow_in(f_up_allow_in), .dn_valid(f_dn_valid), .dn_data(f_dn_data),
    .dn_allow_in(f_dn_allow_in), .count(f_count));

  logic [15:0] qe[$];
  logic [15:0] qf[$];
  logic        e_allow, f_allow, drain;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    {a_flush, a_up_valid, a_dn_allow_in, a_up_data} = '0;
    {b_flush, b_up_valid, b_dn_allow_in, b_up_data} = '0;
    {c_flush, c_up_valid, c_dn_allow_in, c_up_data} = '0;
    {d_flush, d_up_valid, d_dn_allow_in, d_up_data} = '0;
    {e_flush, e_up_valid, e_dn_allow_in, e_up_data} = '0;
    {f_flush, f_up_valid, f_dn_allow_in, f_up_data} = '0;
    #3;
    chk("rst_count", a_count, 0);
    chk("rst_dn_valid", a_dn_valid, 0);
    chk("rst_allow", a_up_allow_in, 1);
    chk("rst_dn_data", a_dn_data, 0);
    chk("rst_count_e", e_count, 0);
    #10 reset = 1'b0;
    tick();

    // Fill DEPTH=4 with no consumer: head stays on the first entry.
    for (int i = 0; i < 4; i++) begin
      a_up_valid = 1'b1;
      a_up_data  = 8'(8'hA0 + i);
      tick();
      chk("fill_count", a_count, i + 1);
      chk("fill_dn_data", a_dn_data, 8'hA0);
      chk("fill_dn_valid", a_dn_valid, 1);
    end
    a_up_valid = 1'b0;
    #1;
    chk("fill_full_allow", a_up_allow_in, 0);

    // Drop to 3 entries, then flush with traffic on both sides.
    a_dn_allow_in = 1'b1;
    tick();
    chk("pop_count", a_count, 3);
    chk("pop_dn_data", a_dn_data, 8'hA1);
    a_flush = 1'b1; a_up_valid = 1'b1; a_up_data = 8'h77;
    tick();
    a_flush = 1'b0; a_dn_allow_in = 1'b0;
    chk("flush_count", a_count, 0);
    chk("flush_dn_valid", a_dn_valid, 0);
    a_up_data = 8'h55;
    tick();
    a_up_valid = 1'b0;
    chk("post_flush_count", a_count, 1);
    chk("post_flush_valid", a_dn_valid, 1);
    chk("post_flush_data", a_dn_data, 8'h55);

    // Asynchronous reset between edges with two entries held.
    a_up_valid = 1'b1; a_up_data = 8'h66;
    tick();
    a_up_valid = 1'b0;
    chk("pre_areset_count", a_count, 2);
    #2 reset = 1'b1;
    #1;
    chk("areset_count", a_count, 0);
    chk("areset_dn_valid", a_dn_valid, 0);
    chk("areset_allow", a_up_allow_in, 1);
    chk("areset_dn_data", a_dn_data, 0);
    #1 reset = 1'b0;
    tick();

    // Streaming through DEPTH=2 PIPE_READY=1 at full rate.
    b_up_valid = 1'b1; b_dn_allow_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b_up_data = 8'(i);
      tick();
      chk("stream_count", b_count, 1);
      chk("stream_valid", b_dn_valid, 1);
      chk("stream_data", b_dn_data, i);
    end
    b_up_valid = 1'b0;
    tick();
    chk("stream_drained", b_count, 0);
    b_dn_allow_in = 1'b0;

    // DEPTH=3 full with simultaneous push/pop in both modes.
    for (int i = 1; i <= 3; i++) begin
      c_up_valid = 1'b1; c_up_data = 8'(i);
      d_up_valid = 1'b1; d_up_data = 8'(i);
      tick();
    end
    chk("d3_full_c", c_count, 3);
    chk("d3_full_d", d_count, 3);
    c_up_data = 8'd4; d_up_data = 8'd4;
    c_dn_allow_in = 1'b1; d_dn_allow_in = 1'b1;
    #1;
    chk("d3_allow_p0", c_up_allow_in, 1);
    chk("d3_allow_p1", d_up_allow_in, 0);
    tick();
    c_up_valid = 1'b0; d_up_valid = 1'b0;
    chk("d3_pp_count_p0", c_count, 3);
    chk("d3_pp_data_p0", c_dn_data, 2);
    chk("d3_pp_count_p1", d_count, 2);
    chk("d3_pp_data_p1", d_dn_data, 2);
    tick();
    chk("d3_drain1_p0", c_dn_data, 3);
    chk("d3_drain1_p1", d_dn_data, 3);
    tick();
    chk("d3_wrap_data_p0", c_dn_data, 4);
    chk("d3_drain2_p1", d_dn_valid, 0);
    tick();
    chk("d3_drain3_p0", c_dn_valid, 0);
    c_dn_allow_in = 1'b0; d_dn_allow_in = 1'b0;

    // Random traffic and occasional flush on DEPTH=5 against queue models.
    for (int n = 0; n < 3000; n++) begin
      drain = (n >= 2980);
      e_flush       = !drain && ($urandom_range(0, 63) == 0);
      e_up_valid    = !drain && ($urandom_range(0, 3) != 0);
      e_up_data     = 16'($urandom);
      e_dn_allow_in = drain || ($urandom_range(0, 1) == 1);
      f_flush       = !drain && ($urandom_range(0, 63) == 0);
      f_up_valid    = !drain && ($urandom_range(0, 3) != 0);
      f_up_data     = 16'($urandom);
      f_dn_allow_in = drain || ($urandom_range(0, 2) == 0);
      #1;
      e_allow = (qe.size() < 5) || (!e_flush && qe.size() != 0 && e_dn_allow_in);
      f_allow = (qf.size() < 5);
      chk("rnd_allow_p0", e_up_allow_in, e_allow);
      chk("rnd_allow_p1", f_up_allow_in, f_allow);
      chk("rnd_valid_p0", e_dn_valid, qe.size() != 0);
      chk("rnd_valid_p1", f_dn_valid, qf.size() != 0);
      if (qe.size() != 0) chk("rnd_data_p0", e_dn_data, qe[0]);
      if (qf.size() != 0) chk("rnd_data_p1", f_dn_data, qf[0]);
      if (e_flush) qe.delete();
      else begin
        if (qe.size() != 0 && e_dn_allow_in) void'(qe.pop_front());
        if (e_up_valid && e_allow) qe.push_back(e_up_data);
      end
      if (f_flush) qf.delete();
      else begin
        if (qf.size() != 0 && f_dn_allow_in) void'(qf.pop_front());
        if (f_up_valid && f_allow) qf.push_back(f_up_data);
      end
      tick();
      chk("rnd_count_p0", e_count, qe.size());
      chk("rnd_count_p1", f_count, qf.size());
    end
    chk("rnd_end_empty_p0", e_count, 0);
    chk("rnd_end_empty_p1", f_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
